// File: rtl/cmp_serial_pkg.sv
// Shared definitions for the bit-serial comparison link: state encodings,
// default operand width and the field layout of one serial beat.
package cmp_serial_pkg;

  localparam int unsigned CMP_WIDTH_DEFAULT = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Beat field positions, shared with the serialized comparator receive side
  localparam int unsigned BEAT_A     = 0;
  localparam int unsigned BEAT_B     = 1;
  localparam int unsigned BEAT_FIRST = 2;
  localparam int unsigned BEAT_LAST  = 3;
  localparam int unsigned BEAT_W     = 4;

  function automatic logic [BEAT_W-1:0] pack_beat(input logic a, input logic b,
                                                  input logic first, input logic last);
    logic [BEAT_W-1:0] beat;
    beat             = '0;
    beat[BEAT_A]     = a;
    beat[BEAT_B]     = b;
    beat[BEAT_FIRST] = first;
    beat[BEAT_LAST]  = last;
    return beat;
  endfunction

endpackage

// File: rtl/operand_shift_reg.sv
// Parallel-load, shift-left operand register; load wins over shift.
module operand_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/comparator_operand_serializer.sv
// Transmit side of the bit-serial comparison link: accepts an operand pair
// and emits it MSB-first as framed bit pairs under receiver backpressure.
module comparator_operand_serializer
  import cmp_serial_pkg::*;
#(
  parameter int unsigned WIDTH      = CMP_WIDTH_DEFAULT,
  parameter bit          EARLY_STOP = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_first,
  output logic             bit_last,
  output logic             busy
);

  localparam int unsigned         IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0]    IDX_TOP = IDX_W'(WIDTH - 1);

  logic [0:0]        state;
  logic [IDX_W-1:0]  idx;
  logic              a_msb;
  logic              b_msb;
  logic              shifting;
  logic              last_raw;
  logic              xfer;
  logic              load;
  logic              step;
  logic [BEAT_W-1:0] beat;

  assign shifting = (state == ST_SHIFT);
  assign last_raw = (idx == '0) | (EARLY_STOP & (a_msb != b_msb));

  // Outputs are gated by state so IDLE never exposes stale shifted bits
  assign beat = pack_beat(shifting & a_msb, shifting & b_msb,
                          shifting & (idx == IDX_TOP), shifting & last_raw);

  assign a_bit     = beat[BEAT_A];
  assign b_bit     = beat[BEAT_B];
  assign bit_first = beat[BEAT_FIRST];
  assign bit_last  = beat[BEAT_LAST];
  assign bit_valid = shifting;
  assign busy      = shifting;

  assign xfer     = bit_valid & bit_ready;
  // A last transfer frees the slot in the same cycle, enabling back-to-back frames
  assign in_ready = reset & (~shifting | (xfer & bit_last));
  assign load     = in_valid & in_ready;
  assign step     = xfer & ~bit_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else if (load) begin
      state <= ST_SHIFT;
      idx   <= IDX_TOP;
    end else if (xfer & bit_last) begin
      state <= ST_IDLE;
    end else if (step) begin
      idx <= idx - 1'b1;
    end
  end

  operand_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (step),
    .d     (a_in),
    .msb   (a_msb)
  );

  operand_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (step),
    .d     (b_in),
    .msb   (b_msb)
  );

endmodule

// File: tb/tb_comparator_operand_serializer.sv
// Scoreboard bench for comparator_operand_serializer across three configurations:
// WIDTH=4 plain, WIDTH=4 early-stop, WIDTH=1.
module tb_comparator_operand_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       bit_valid [3];
  logic       bit_ready [3];
  logic       a_bit     [3];
  logic       b_bit     [3];
  logic       bit_first [3];
  logic       bit_last  [3];
  logic       busy      [3];
  logic [3:0] a_in      [3];
  logic [3:0] b_in      [3];

  comparator_operand_serializer #(.WIDTH(4), .EARLY_STOP(1'b0)) dut0 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a_in(a_in[0]), .b_in(b_in[0]), .bit_valid(bit_valid[0]), .bit_ready(bit_ready[0]),
    .a_bit(a_bit[0]), .b_bit(b_bit[0]), .bit_first(bit_first[0]), .bit_last(bit_last[0]),
    .busy(busy[0]));

  comparator_operand_serializer #(.WIDTH(4), .EARLY_STOP(1'b1)) dut1 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a_in(a_in[1]), .b_in(b_in[1]), .bit_valid(bit_valid[1]), .bit_ready(bit_ready[1]),
    .a_bit(a_bit[1]), .b_bit(b_bit[1]), .bit_first(bit_first[1]), .bit_last(bit_last[1]),
    .busy(busy[1]));

  comparator_operand_serializer #(.WIDTH(1), .EARLY_STOP(1'b0)) dut2 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a_in(a_in[2][0:0]), .b_in(b_in[2][0:0]), .bit_valid(bit_valid[2]), .bit_ready(bit_ready[2]),
    .a_bit(a_bit[2]), .b_bit(b_bit[2]), .bit_first(bit_first[2]), .bit_last(bit_last[2]),
    .busy(busy[2]));

  typedef struct {
    int         dut;
    logic [3:0] beat;   // {a, b, first, last}
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   gap_cnt = 0;
  bit   track_gap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic void push_frame(input int d, input int w, input bit es,
                                     input logic [3:0] a, input logic [3:0] b);
    logic ab, bb, f, l;
    for (int i = w - 1; i >= 0; i--) begin
      ab = a[i];
      bb = b[i];
      f  = (i == w - 1);
      l  = (i == 0) || (es && (ab != bb));
      exp_q.push_back('{d, {ab, bb, f, l}});
      if (l) break;
    end
  endfunction

  // Scoreboard: every transferred beat must match the next expected beat
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n && bit_valid[d] && bit_ready[d]) begin
        if (exp_q.size() == 0) begin
          check("beat_extra_dut", d, -1);
        end else begin
          e = exp_q.pop_front();
          check("beat_dut", d, e.dut);
          check("beat_abfl", {a_bit[d], b_bit[d], bit_first[d], bit_last[d]}, e.beat);
          if (bit_last[d]) check("in_ready_last", in_ready[d], 1);
        end
      end
    end
    if (track_gap && exp_q.size() != 0 && !bit_valid[0]) gap_cnt++;
  end

  task automatic send(input int d, input int w, input bit es,
                      input logic [3:0] a, input logic [3:0] b);
    bit acc;
    acc = 1'b0;
    push_frame(d, w, es, a, b);
    in_valid[d] = 1'b1;
    a_in[d]     = a;
    b_in[d]     = b;
    for (int c = 0; c < 64 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready[d];
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b0;
    check("accept", acc, 1);
    check("first_latency", {bit_valid[d], bit_first[d]}, 2'b11);
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      bit_ready[d] = 1'b1;
      a_in[d]      = '0;
      b_in[d]      = '0;
    end
    rst_n = 1'b0;
    #3;
    for (int d = 0; d < 3; d++) begin
      check("rst_bit_valid", bit_valid[d], 0);
      check("rst_busy", busy[d], 0);
      check("rst_in_ready", in_ready[d], 0);
      check("rst_beat", {a_bit[d], b_bit[d], bit_first[d], bit_last[d]}, 0);
    end
    #19 rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready0", in_ready[0], 1);
    check("idle_in_ready2", in_ready[2], 1);
    check("idle_bit_valid", bit_valid[0], 0);
    @(posedge clk);
    #1;

    // Basic frame, plain serializer
    send(0, 4, 1'b0, 4'hA, 4'hB);
    drain();
    check("idle_after_frame", busy[0], 0);

    // Early stop: equal operands, MSB difference, mid-frame difference
    send(1, 4, 1'b1, 4'h8, 4'h8);
    drain();
    send(1, 4, 1'b1, 4'h8, 4'h3);
    drain();
    send(1, 4, 1'b1, 4'h4, 4'h6);
    drain();

    // Backpressure on beat 2
    send(0, 4, 1'b0, 4'h5, 4'h6);
    @(posedge clk);
    #1;
    bit_ready[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_hold", {a_bit[0], b_bit[0], bit_first[0], bit_last[0]}, 4'b1100);
      check("stall_valid", bit_valid[0], 1);
      check("stall_in_ready", in_ready[0], 0);
    end
    @(posedge clk);
    #1;
    bit_ready[0] = 1'b1;
    drain();

    // Back-to-back frames with no idle gap
    send(0, 4, 1'b0, 4'hA, 4'hB);
    gap_cnt   = 0;
    track_gap = 1'b1;
    send(0, 4, 1'b0, 4'h3, 4'h3);
    drain();
    track_gap = 1'b0;
    check("b2b_gap", gap_cnt, 0);

    // Asynchronous reset mid-frame after beat 2
    send(0, 4, 1'b0, 4'hA, 4'hB);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    #2 rst_n = 1'b0;
    #1;
    check("abort_bit_valid", bit_valid[0], 0);
    check("abort_busy", busy[0], 0);
    check("abort_beat", {a_bit[0], b_bit[0], bit_first[0], bit_last[0]}, 0);
    check("abort_in_ready", in_ready[0], 0);
    exp_q.delete();
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready[0], 1);
    check("post_rst_busy", busy[0], 0);
    @(posedge clk);
    #1;
    send(0, 4, 1'b0, 4'h9, 4'h6);
    drain();

    // Single-bit operands
    send(2, 1, 1'b0, 4'h1, 4'h0);
    drain();

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
